// File: rtl/vstructs.sv
`default_nettype none
// ============================================================================
// Package     : vstructs
// Description : Vector instruction record exchanged between issue stages.
// Revision    : 1.0 - initial release
// ============================================================================
package vstructs;

    localparam int VL_FIELD_W = 32;

    typedef struct packed {
        logic                  valid;
        logic                  reconfigure;
        logic [7:0]            op;
        logic [4:0]            vd;
        logic [4:0]            vs1;
        logic [4:0]            vs2;
        logic [VL_FIELD_W-1:0] vl;
        logic [VL_FIELD_W-1:0] maxvl;
    } to_vector;

endpackage
`default_nettype wire

// File: rtl/vinstr_receiver.sv
`default_nettype none
// ============================================================================
// Module      : vinstr_receiver
// Description : Vector instruction FIFO that stamps vl/maxvl on each accepted
//               instruction and serialises reconfigure requests behind it.
//               Optional counters: define VINSTR_RECEIVER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vinstr_receiver
    import vstructs::*;
#(
    parameter int DEPTH            = 4,
    parameter int VECTOR_REGISTERS = 32,
    parameter int VECTOR_LANES     = 8,
    localparam int VLW             = $clog2(VECTOR_REGISTERS*VECTOR_LANES) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           valid_i,
    input  to_vector       instr_i,
    output logic           pop_o,
    output logic           valid_o,
    output to_vector       instr_o,
    input  logic           ready_i,
    output logic [VLW-1:0] vl_o,
    output logic [VLW-1:0] maxvl_o,
    output logic           busy_o,
    output logic [31:0]    stat_accepted_o,
    output logic [31:0]    stat_reconfig_o,
    output logic [31:0]    stat_stall_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_CONFIG = 2'd2
    } state_t;

    state_t         state_q;
    logic [VLW-1:0] vl_q;
    logic [VLW-1:0] maxvl_q;
    logic [AW:0]    wr_ptr_q;
    logic [AW:0]    rd_ptr_q;
    to_vector       mem_q [DEPTH];

    logic           w_empty;
    logic           w_full;
    logic           w_deq;
    logic           w_enq;
    logic           w_accept_ok;
    logic           w_pop;
    logic           w_cfg_pop;
    logic [VLW-1:0] w_cfg_vl;
    logic [VLW-1:0] w_cfg_maxvl;
    to_vector       w_enq_instr;

    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign w_deq   = !w_empty && ready_i;

    always_comb begin
        w_accept_ok = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (instr_i.reconfigure)
                    w_accept_ok = 1'b0;
                else if (vl_q == '0)
                    w_accept_ok = 1'b1;          // vl==0: consume and drop
                else
                    w_accept_ok = !w_full || w_deq;
            end
            ST_DRAIN:  w_accept_ok = 1'b0;
            ST_CONFIG: w_accept_ok = instr_i.reconfigure;
            default:   w_accept_ok = 1'b0;
        endcase
    end

    assign w_pop     = valid_i && w_accept_ok;
    assign w_enq     = w_pop && (state_q == ST_RUN) && !instr_i.reconfigure &&
                       (vl_q != '0);
    assign w_cfg_pop = w_pop && (state_q == ST_CONFIG);

    assign w_cfg_maxvl = instr_i.maxvl[VLW-1:0];
    assign w_cfg_vl    = (instr_i.vl[VLW-1:0] < w_cfg_maxvl) ? instr_i.vl[VLW-1:0]
                                                             : w_cfg_maxvl;

    always_comb begin
        w_enq_instr       = instr_i;
        w_enq_instr.valid = 1'b1;
        w_enq_instr.vl    = {{(VL_FIELD_W-VLW){1'b0}}, vl_q};
        w_enq_instr.maxvl = {{(VL_FIELD_W-VLW){1'b0}}, maxvl_q};
    end

    // Controller: state plus the architectural vl/maxvl it owns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            vl_q    <= '0;
            maxvl_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (valid_i && instr_i.reconfigure)
                        state_q <= w_empty ? ST_CONFIG : ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!valid_i || !instr_i.reconfigure)
                        state_q <= ST_RUN;
                    else if (w_empty)
                        state_q <= ST_CONFIG;
                end
                ST_CONFIG: begin
                    if (w_cfg_pop) begin
                        vl_q    <= w_cfg_vl;
                        maxvl_q <= w_cfg_maxvl;
                    end
                    state_q <= ST_RUN;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_enq)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_deq)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_enq)
            mem_q[wr_ptr_q[AW-1:0]] <= w_enq_instr;
    end

    assign pop_o   = w_pop;
    assign valid_o = !w_empty;
    assign instr_o = mem_q[rd_ptr_q[AW-1:0]];
    assign vl_o    = vl_q;
    assign maxvl_o = maxvl_q;
    assign busy_o  = !w_empty || (state_q != ST_RUN);

`ifdef VINSTR_RECEIVER_STATS_EN
    logic [31:0] stat_accepted_q;
    logic [31:0] stat_reconfig_q;
    logic [31:0] stat_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_accepted_q <= '0;
            stat_reconfig_q <= '0;
            stat_stall_q    <= '0;
        end else begin
            if (w_enq)
                stat_accepted_q <= stat_accepted_q + 32'd1;
            if (w_cfg_pop)
                stat_reconfig_q <= stat_reconfig_q + 32'd1;
            if (valid_i && !w_pop)
                stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_accepted_o = stat_accepted_q;
    assign stat_reconfig_o = stat_reconfig_q;
    assign stat_stall_o    = stat_stall_q;
`else
    assign stat_accepted_o = '0;
    assign stat_reconfig_o = '0;
    assign stat_stall_o    = '0;
`endif

endmodule
`default_nettype wire
